shift_ift_pipe: RTL and testbench
=================================

Name: shift_ift_pipe

Overview:
- Pipelined, parametrised shifter/rotator with dynamic information-flow tracking (IFT).
- Each data operand carries a taint label; the label propagates to the result with a fixed rule.
- Generalises the combinational 2-bit shift cell used in the IFT test cells. Adds width/depth parameters, four shift modes, valid/ready flow control and a sticky taint monitor.
- Used as a reference sequential cell when checking the IFT instrumentation flow.

Parameters:
- WIDTH, 8, data width. Must be a power of two, at least 2.
- BW, $clog2(WIDTH)+1, shift-amount width. The extra bit allows over-shift.
- TW, 32, taint label width.
- STAGES, 2, pipeline register stages, 1..$clog2(WIDTH). This is also the latency.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- a  in  WIDTH  data to shift.
- a_t  in  TW  taint label of a.
- b  in  BW  shift amount.
- b_t  in  TW  taint label of b.
- mode  in  2  00 SHL, 01 SHR (logical), 10 SSHR (arithmetic), 11 ROL.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- y  out  WIDTH  shifted result.
- y_t  out  TW  taint label of y.
- taint_seen  out  1  sticky: set once any result with nonzero y_t has been transferred.

Behaviour:
- Reset, asynchronous and active-high:
  - all stage valid bits cleared;
  - y=0, y_t=0, out_valid=0, taint_seen=0;
  - in_ready=1 on the first cycle after release.
  - Operations in flight are discarded. No partial result is ever emitted.
- Transfers:
  - Input transfer happens on a clk edge with in_valid && in_ready.
  - Output transfer happens on a clk edge with out_valid && out_ready.
- Pipeline:
  - STAGES register stages, each holding valid, partial data, b, mode and taint.
  - The $clog2(WIDTH) barrel levels (level k shifts by 2^k when b[k]) are split across the stages. Earlier stages take the extra level when the split is uneven.
  - Stage i advances when it is valid and stage i+1 is empty or advancing. The last stage advances on out_ready.
  - in_ready = !valid[0] || advance[0]. This is a combinational path from out_ready back through the stall chain.
- Timing:
  - Latency is exactly STAGES cycles from input transfer to out_valid when there is no backpressure.
  - Throughput is 1 operand per cycle.
  - While out_valid=1 && out_ready=0, y and y_t must hold stable.
- Simultaneous events: with the pipe full and out_ready=1, an input transfer and an output transfer occur in the same cycle and no bubble is inserted.
- Arithmetic when b >= WIDTH:
  - SHL and SHR give 0.
  - SSHR gives all bits equal to a[WIDTH-1].
  - ROL uses b mod WIDTH.
- Taint rule (default): y_t = a_t | b_t, captured at input transfer and carried through the pipe.
- taint_seen:
  - Set on an output transfer with y_t != 0.
  - Cleared only by rst.

Optional Feature:
- Macro: SHIFT_IFT_PRECISE_EN.
- Defined: precise taint.
  - If mode is SHL or SHR, b >= WIDTH and b_t == 0, then y_t = 0, because the result is constant and independent of a.
  - If b_t == 0 and a_t == 0, then y_t = 0.
  - Otherwise the default rule applies.
- Undefined: conservative rule y_t = a_t | b_t always.

Decomposition:
- Package shift_ift_pkg holds:
  - mode enum shift_mode_e (SHL, SHR, SSHR, ROL);
  - typedef taint_t (logic [TW-1:0]);
  - function taint_join.
- One sub-module, shift_ift_level: a single combinational barrel level with parameter SHAMT. It is instantiated $clog2(WIDTH) times and wired into the stages.

Test Plan (all with WIDTH=8, STAGES=2, TW=32):
- Reset, then a=8'hB4, b=3, mode=SHL, a_t=1, b_t=0, out_ready=1 -> two cycles later y=8'hA0, y_t=32'h1, out_valid=1, taint_seen=1 after the transfer.
- Sweep all modes with a=8'h81, b in {0,1,7,8,9}. Required results:
  - SHL b=1: 8'h02.
  - SHR b=7: 8'h01.
  - SSHR b=9: 8'hFF.
  - ROL b=9: 8'h03.
  - SHL b=8: 8'h00.
- Backpressure: stream 4 operands back-to-back with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, y is stable while stalled, all 4 results then emerge in order with no loss or duplication.
- Over-shift taint: mode=SHR, b=8, a_t=32'h4, b_t=0.
  - Macro defined: y_t=0.
  - Macro undefined: y_t=32'h4.
  - In both cases y=0.
- Reset mid-operation: assert rst with 2 operands in flight -> out_valid, y, y_t and taint_seen are all 0 immediately (asynchronous); no stale result appears after release.
- Shift-amount taint: a_t=0, b_t=32'h8000_0000, mode=ROL, a=8'h01, b=2 -> y=8'h04, y_t=32'h8000_0000 in both builds.

Source files
------------

// File: rtl/shift_ift_pkg.sv
// shift_ift_pkg: shift modes, taint label type and helpers for the IFT shift pipe
package shift_ift_pkg;
  localparam int TAINT_W = 32;
  typedef enum logic [1:0] {SHL = 2'b00, SHR = 2'b01, SSHR = 2'b10, ROL = 2'b11} shift_mode_e;
  typedef logic [TAINT_W-1:0] taint_t;
  function automatic taint_t taint_join(taint_t x, taint_t z);
    return x | z;
  endfunction
  // first barrel level owned by stage i when l levels are split over s stages, earlier stages taking the remainder
  function automatic int lvl_lo(int i, int l, int s);
    return i * (l / s) + ((i < l % s) ? i : l % s);
  endfunction
endpackage

// File: rtl/shift_ift_pipe_if.sv
// shift_ift_pipe_if: operand/result handshake bundle for shift_ift_pipe
interface shift_ift_pipe_if #(
  parameter int WIDTH = 8,
  parameter int BW = $clog2(WIDTH) + 1,
  parameter int TW = 32
);
  import shift_ift_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready, taint_seen;
  logic [WIDTH-1:0] a, y;
  logic [BW-1:0] b;
  logic [TW-1:0] a_t, b_t, y_t;
  shift_mode_e mode;
  modport master (output in_valid, a, a_t, b, b_t, mode, out_ready,
                  input in_ready, out_valid, y, y_t, taint_seen);
  modport slave (input in_valid, a, a_t, b, b_t, mode, out_ready,
                 output in_ready, out_valid, y, y_t, taint_seen);
endinterface

// File: rtl/shift_ift_level.sv
// shift_ift_level: one barrel level shifting/rotating by SHAMT when en is set
module shift_ift_level import shift_ift_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SHAMT = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s;
  always_comb begin
    s = mode == SHL ? d << SHAMT :
        mode == SHR ? d >> SHAMT :
        mode == SSHR ? {{SHAMT{d[WIDTH-1]}}, d[WIDTH-1:SHAMT]} :
        {d[WIDTH-SHAMT-1:0], d[WIDTH-1:WIDTH-SHAMT]};
    q = en ? s : d;
  end
endmodule

// File: rtl/shift_ift_pipe.sv
// shift_ift_pipe: pipelined shifter/rotator with taint propagation and sticky taint monitor.
// Define SHIFT_IFT_PRECISE_EN to clear the label of over-shifted SHL/SHR results whose amount is untainted.
module shift_ift_pipe import shift_ift_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int BW = $clog2(WIDTH) + 1,
  parameter int TW = 32,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst,
  shift_ift_pipe_if.slave bus
);
  localparam int L = $clog2(WIDTH);
  logic [STAGES:0] free;
  logic [STAGES-1:0] v, adv, take;
  logic [WIDTH-1:0] d [STAGES], sin [STAGES], nd [STAGES];
  logic [L-1:0] sb [STAGES], sb_in [STAGES];
  shift_mode_e m [STAGES], m_in [STAGES];
  logic [TW-1:0] t [STAGES], st_in [STAGES];
  logic [WIDTH-1:0] ch [L];
  logic [TW-1:0] tj, t_in;
  logic [WIDTH-1:0] a_fix;
  logic over, seen;
  // over-shift is resolved up front so the levels only ever see b mod WIDTH
  assign over = bus.b[BW-1];
  assign a_fix = (over && bus.mode != ROL) ? (bus.mode == SSHR ? {WIDTH{bus.a[WIDTH-1]}} : '0) : bus.a;
  if (TW == TAINT_W) begin : g_join_pkg
    assign tj = taint_join(bus.a_t, bus.b_t);
  end else begin : g_join_wide
    assign tj = bus.a_t | bus.b_t;
  end
`ifdef SHIFT_IFT_PRECISE_EN
  assign t_in = (over && (bus.mode == SHL || bus.mode == SHR) && bus.b_t == '0) ? '0 : tj;
`else
  assign t_in = tj;
`endif
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int LO = lvl_lo(i, L, STAGES);
    localparam int HI = lvl_lo(i + 1, L, STAGES);
    assign nd[i] = ch[HI-1];
    if (i == 0) begin : g_head
      assign sin[i] = a_fix;
      assign sb_in[i] = bus.b[L-1:0];
      assign m_in[i] = bus.mode;
      assign st_in[i] = t_in;
    end else begin : g_body
      assign sin[i] = d[i-1];
      assign sb_in[i] = sb[i-1];
      assign m_in[i] = m[i-1];
      assign st_in[i] = t[i-1];
    end
    for (genvar j = LO; j < HI; j++) begin : g_lvl
      if (j == LO) begin : g_first
        shift_ift_level #(.WIDTH(WIDTH), .SHAMT(1 << j)) u_lvl (
          .d(sin[i]), .en(sb_in[i][j]), .mode(m_in[i]), .q(ch[j]));
      end else begin : g_next
        shift_ift_level #(.WIDTH(WIDTH), .SHAMT(1 << j)) u_lvl (
          .d(ch[j-1]), .en(sb_in[i][j]), .mode(m_in[i]), .q(ch[j]));
      end
    end
  end
  // stall chain: a stage moves when the one behind it is free; free ripples back from out_ready
  always_comb begin
    free = '0;
    adv = '0;
    take = '0;
    free[STAGES] = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = v[i] && free[i+1];
      free[i] = !v[i] || adv[i];
    end
    take[0] = bus.in_valid && free[0];
    for (int i = 1; i < STAGES; i++) take[i] = adv[i-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      seen <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
        sb[i] <= '0;
        m[i] <= SHL;
        t[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (take[i]) begin
          v[i] <= 1'b1;
          d[i] <= nd[i];
          sb[i] <= sb_in[i];
          m[i] <= m_in[i];
          t[i] <= st_in[i];
        end else if (adv[i]) begin
          v[i] <= 1'b0;
        end
      end
      if (v[STAGES-1] && bus.out_ready && |t[STAGES-1]) seen <= 1'b1;
    end
  end
  assign bus.in_ready = free[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.y = d[STAGES-1];
  assign bus.y_t = t[STAGES-1];
  assign bus.taint_seen = seen;
endmodule

// File: tb/tb_shift_ift_pipe.sv
// tb_shift_ift_pipe: directed self-checking bench for shift_ift_pipe (WIDTH=8, STAGES=2, TW=32)
module tb_shift_ift_pipe;
  import shift_ift_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  shift_ift_pipe_if bus ();
  shift_ift_pipe dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
`ifdef SHIFT_IFT_PRECISE_EN
  localparam taint_t OVER_T = 32'h0;
`else
  localparam taint_t OVER_T = 32'h4;
`endif
  logic [3:0] sweep_b [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9};
  logic [7:0] sweep_y [20] = '{8'h81, 8'h02, 8'h80, 8'h00, 8'h00,
                               8'h81, 8'h40, 8'h01, 8'h00, 8'h00,
                               8'h81, 8'hC0, 8'hFF, 8'hFF, 8'hFF,
                               8'h81, 8'h03, 8'hC0, 8'h81, 8'h03};

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input shift_mode_e md,
                        input taint_t at, input taint_t bt,
                        output logic [7:0] y, output taint_t yt, output logic ok);
    int n = 0;
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.mode = md; bus.a_t = at; bus.b_t = bt;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus.out_valid; y = bus.y; yt = bus.y_t;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.a = '0; bus.b = '0;
    bus.mode = SHL; bus.a_t = '0; bus.b_t = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vecs++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.y !== 8'h00 || bus.y_t !== 32'h0 || bus.taint_seen !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b y=%h y_t=%h taint_seen=%b, required 1 0 00 00000000 0",
               bus.in_ready, bus.out_valid, bus.y, bus.y_t, bus.taint_seen);
    end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    bus.a = 8'hB4; bus.b = 4'd3; bus.mode = SHL; bus.a_t = 32'h1; bus.b_t = 32'h0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vecs++;
    if (bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_latency1: out_valid=%b, required 0", bus.out_valid);
    end
    @(posedge clk); #1;
    vecs++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'hA0 || bus.y_t !== 32'h1 || bus.taint_seen !== 1'b0) begin
      errs++;
      $display("FAIL basic_result: out_valid=%b y=%h y_t=%h taint_seen=%b, required 1 a0 00000001 0",
               bus.out_valid, bus.y, bus.y_t, bus.taint_seen);
    end
    @(posedge clk); #1;
    vecs++;
    if (bus.taint_seen !== 1'b1 || bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_taint_seen: taint_seen=%b out_valid=%b, required 1 0", bus.taint_seen, bus.out_valid);
    end
  endtask

  task automatic test_modes();
    logic [7:0] y;
    taint_t yt;
    logic ok;
    for (int mi = 0; mi < 4; mi++) begin
      for (int bi = 0; bi < 5; bi++) begin
        run_op(8'h81, sweep_b[bi], shift_mode_e'(mi), 32'h0, 32'h0, y, yt, ok);
        vecs++;
        if (ok !== 1'b1 || y !== sweep_y[mi*5+bi] || yt !== 32'h0) begin
          errs++;
          $display("FAIL mode_sweep mode=%0d b=%0d: valid=%b y=%h y_t=%h, required 1 %h 00000000",
                   mi, sweep_b[bi], ok, y, yt, sweep_y[mi*5+bi]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got_y [$];
    taint_t got_t [$];
    int idx = 0;
    logic rdy, fire;
    logic [7:0] cy;
    taint_t ct;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.b = 4'd1; bus.mode = SHL; bus.b_t = '0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = idx < 4; bus.a = 8'(idx + 1); bus.a_t = taint_t'(idx + 1);
      #1 rdy = bus.in_ready;
      if (c >= 2) begin
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.y !== 8'h02 || bus.y_t !== 32'h1 || rdy !== 1'b0) begin
          errs++;
          $display("FAIL stall_hold c=%0d: out_valid=%b y=%h y_t=%h in_ready=%b, required 1 02 00000001 0",
                   c, bus.out_valid, bus.y, bus.y_t, rdy);
        end
      end
      @(posedge clk);
      if (rdy && bus.in_valid) idx++;
      #1;
    end
    vecs++;
    if (idx !== 2) begin
      errs++;
      $display("FAIL stall_accept_count: accepted=%0d, required 2", idx);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && got_y.size() < 4; c++) begin
      bus.in_valid = idx < 4; bus.a = 8'(idx + 1); bus.a_t = taint_t'(idx + 1);
      #1 rdy = bus.in_ready;
      fire = bus.out_valid && bus.out_ready;
      cy = bus.y; ct = bus.y_t;
      @(posedge clk);
      if (rdy && bus.in_valid) idx++;
      if (fire) begin
        got_y.push_back(cy);
        got_t.push_back(ct);
      end
      #1;
    end
    bus.in_valid = 1'b0;
    vecs++;
    if (got_y.size() != 4) begin
      errs++;
      $display("FAIL drain_count: results=%0d, required 4", got_y.size());
    end
    for (int k = 0; k < got_y.size() && k < 4; k++) begin
      vecs++;
      if (got_y[k] !== 8'(2 * (k + 1)) || got_t[k] !== taint_t'(k + 1)) begin
        errs++;
        $display("FAIL drain_order k=%0d: y=%h y_t=%h, required %h %h", k, got_y[k], got_t[k], 8'(2 * (k + 1)), taint_t'(k + 1));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL drain_no_dup: out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_overshift_taint();
    logic [7:0] y;
    taint_t yt;
    logic ok;
    run_op(8'hC3, 4'd8, SHR, 32'h4, 32'h0, y, yt, ok);
    vecs++;
    if (ok !== 1'b1 || y !== 8'h00 || yt !== OVER_T) begin
      errs++;
      $display("FAIL overshift_taint: valid=%b y=%h y_t=%h, required 1 00 %h", ok, y, yt, OVER_T);
    end
  endtask

  task automatic test_amount_taint();
    logic [7:0] y;
    taint_t yt;
    logic ok;
    run_op(8'h01, 4'd2, ROL, 32'h0, 32'h8000_0000, y, yt, ok);
    vecs++;
    if (ok !== 1'b1 || y !== 8'h04 || yt !== 32'h8000_0000) begin
      errs++;
      $display("FAIL amount_taint: valid=%b y=%h y_t=%h, required 1 04 80000000", ok, y, yt);
    end
  endtask

  task automatic test_reset_mid();
    logic stale = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.a = 8'hFF; bus.b = 4'd1; bus.mode = SHL;
    bus.a_t = 32'h1; bus.b_t = 32'h0; bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    vecs++;
    if (bus.out_valid !== 1'b1 || bus.taint_seen !== 1'b1) begin
      errs++;
      $display("FAIL midreset_pre: out_valid=%b taint_seen=%b, required 1 1", bus.out_valid, bus.taint_seen);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.y !== 8'h00 || bus.y_t !== 32'h0 || bus.taint_seen !== 1'b0) begin
      errs++;
      $display("FAIL midreset_async: out_valid=%b y=%h y_t=%h taint_seen=%b, required 0 00 00000000 0",
               bus.out_valid, bus.y, bus.y_t, bus.taint_seen);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    vecs++;
    if (stale !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL midreset_stale: stale_valid=%b in_ready=%b, required 0 1", stale, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_backpressure();
    test_overshift_taint();
    test_amount_taint();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
